life_board: RTL and testbench

LIFE_BOARD -- requirements
Module: life_board

---
 rtl/life_pkg.sv | 22 ++
 rtl/life_cell.sv | 51 +++++
 rtl/life_board.sv | 103 ++++++++++
 tb/tb_life_board.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/life_pkg.sv
// life_pkg -- shared types, rule masks and index helper for the life_board
// cellular automaton.
package life_pkg;

  // Live-neighbour count of one cell, 0..8.
  typedef logic [3:0] nbr_cnt_t;

  // Bit n of birth/survive selects neighbour count n.
  typedef struct packed {
    logic [8:0] birth;
    logic [8:0] survive;
  } rule_t;

  localparam rule_t RULE_B3_S23  = '{birth: 9'b000001000, survive: 9'b000001100};
  localparam rule_t RULE_B36_S23 = '{birth: 9'b001001000, survive: 9'b000001100};

  // Flat bit position of cell (r,c) in the board vectors.
  function automatic int rc_to_idx(input int r, input int c, input int cols);
    return r * cols + c;
  endfunction

endpackage

// File: rtl/life_cell.sv
// life_cell -- one board cell: its state flop, the eight-input neighbour
// count and the rule lookup. The pre-edge next value is exported so the board
// can detect a step that changes nothing.
module life_cell
  import life_pkg::*;
#(
  parameter logic [8:0] BIRTH_MASK   = RULE_B3_S23.birth,
  parameter logic [8:0] SURVIVE_MASK = RULE_B3_S23.survive
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       load,
  input  logic       init_i,
  input  logic [7:0] nbr_i,
  output logic       cell_o,
  output logic       next_o
);

  logic     cell_q;
  logic     cell_d;
  nbr_cnt_t cnt;

  // Population count of the eight neighbours.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < 8; i++) begin
      cnt = cnt + nbr_cnt_t'(nbr_i[i]);
    end
  end

  // Rule lookup: birth mask for a dead cell, survive mask for a live one.
  always_comb begin
    cell_d = cell_q ? SURVIVE_MASK[cnt] : BIRTH_MASK[cnt];
  end

  // Cell state: reset and load both seed from init_i; ena advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      cell_q <= init_i;
    end else if (load) begin
      cell_q <= init_i;
    end else if (ena) begin
      cell_q <= cell_d;
    end
  end

  assign cell_o = cell_q;
  assign next_o = cell_d;

endmodule

// File: rtl/life_board.sv
// life_board -- ROWS x COLS Life-like cellular automaton. One generation per
// cycle with ena; load/rst seed the board from init_state.
// Optional macro LIFE_BOARD_TORUS_EN: edges wrap around (torus). Without it,
// off-board neighbours read as dead.
module life_board
  import life_pkg::*;
#(
  parameter int         ROWS         = 8,
  parameter int         COLS         = 8,
  parameter logic [8:0] BIRTH_MASK   = RULE_B3_S23.birth,
  parameter logic [8:0] SURVIVE_MASK = RULE_B3_S23.survive,
  parameter int         GEN_W        = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic                 load,
  input  logic [ROWS*COLS-1:0] init_state,
  output logic [ROWS*COLS-1:0] cells_q,
  output logic [GEN_W-1:0]     gen_count,
  output logic                 still,
  output logic                 extinct
);

  localparam int NCELL = ROWS * COLS;

  logic [NCELL-1:0] cells_next;
  logic [GEN_W-1:0] gen_q;
  logic [GEN_W-1:0] gen_d;
  logic             still_q;
  logic             still_d;

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      localparam int IDX = rc_to_idx(r, c, COLS);
      logic [7:0] nbr;

      // Neighbour slots are the 3x3 window around (r,c) minus the centre,
      // numbered row-major 0..7.
      for (genvar dr = 0; dr < 3; dr++) begin : g_dr
        for (genvar dc = 0; dc < 3; dc++) begin : g_dc
          if (!(dr == 1 && dc == 1)) begin : g_nb
            localparam int RAW  = dr * 3 + dc;
            localparam int SLOT = (RAW > 4) ? RAW - 1 : RAW;
            localparam int NR   = r + dr - 1;
            localparam int NC   = c + dc - 1;
`ifdef LIFE_BOARD_TORUS_EN
            localparam int WR = (NR + ROWS) % ROWS;
            localparam int WC = (NC + COLS) % COLS;
            assign nbr[SLOT] = cells_q[rc_to_idx(WR, WC, COLS)];
`else
            if (NR >= 0 && NR < ROWS && NC >= 0 && NC < COLS) begin : g_on
              assign nbr[SLOT] = cells_q[rc_to_idx(NR, NC, COLS)];
            end else begin : g_off
              assign nbr[SLOT] = 1'b0;
            end
`endif
          end
        end
      end

      life_cell #(
        .BIRTH_MASK  (BIRTH_MASK),
        .SURVIVE_MASK(SURVIVE_MASK)
      ) u_cell (
        .clk   (clk),
        .rst   (rst),
        .ena   (ena),
        .load  (load),
        .init_i(init_state[IDX]),
        .nbr_i (nbr),
        .cell_o(cells_q[IDX]),
        .next_o(cells_next[IDX])
      );
    end
  end

  // Saturating generation count and no-change detection for the pending step.
  always_comb begin
    gen_d   = (gen_q == {GEN_W{1'b1}}) ? gen_q : gen_q + GEN_W'(1);
    still_d = (cells_next == cells_q);
  end

  // Generation and still registers follow the same rst > load > ena priority
  // as the cells.
  always_ff @(posedge clk) begin
    if (rst) begin
      gen_q   <= '0;
      still_q <= 1'b0;
    end else if (load) begin
      gen_q   <= '0;
      still_q <= 1'b0;
    end else if (ena) begin
      gen_q   <= gen_d;
      still_q <= still_d;
    end
  end

  assign gen_count = gen_q;
  assign still     = still_q;
  assign extinct   = ~|cells_q;

endmodule

// File: tb/tb_life_board.sv
// Directed bench for life_board on 5x5 boards: B3/S23, B36/S23 and a
// GEN_W=3 instance share all inputs. Expected boards are hand-computed.
module tb_life_board;
  import life_pkg::*;

  localparam int R = 5;
  localparam int C = 5;
  localparam int N = R * C;

  logic         clk = 1'b0;
  logic         rst;
  logic         ena;
  logic         load;
  logic [N-1:0] init_state;

  logic [N-1:0] cells_a, cells_b, cells_c;
  logic [15:0]  gen_a, gen_b;
  logic [2:0]   gen_c;
  logic         still_a, still_b, still_c;
  logic         ext_a, ext_b, ext_c;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  life_board #(.ROWS(R), .COLS(C), .BIRTH_MASK(RULE_B3_S23.birth),
               .SURVIVE_MASK(RULE_B3_S23.survive), .GEN_W(16)) dut_a (
    .clk(clk), .rst(rst), .ena(ena), .load(load), .init_state(init_state),
    .cells_q(cells_a), .gen_count(gen_a), .still(still_a), .extinct(ext_a));

  life_board #(.ROWS(R), .COLS(C), .BIRTH_MASK(RULE_B36_S23.birth),
               .SURVIVE_MASK(RULE_B36_S23.survive), .GEN_W(16)) dut_b (
    .clk(clk), .rst(rst), .ena(ena), .load(load), .init_state(init_state),
    .cells_q(cells_b), .gen_count(gen_b), .still(still_b), .extinct(ext_b));

  life_board #(.ROWS(R), .COLS(C), .BIRTH_MASK(RULE_B3_S23.birth),
               .SURVIVE_MASK(RULE_B3_S23.survive), .GEN_W(3)) dut_c (
    .clk(clk), .rst(rst), .ena(ena), .load(load), .init_state(init_state),
    .cells_q(cells_c), .gen_count(gen_c), .still(still_c), .extinct(ext_c));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] px(input int r, input int c);
    logic [N-1:0] v;
    v = '0;
    v[r * C + c] = 1'b1;
    return v;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [N-1:0] pat);
    init_state = pat;
    load = 1'b1;
    ena  = 1'b0;
    tick(1);
    load = 1'b0;
  endtask

  task automatic do_ena(input int n);
    ena = 1'b1;
    tick(n);
    ena = 1'b0;
  endtask

  logic [N-1:0] blink_v, blink_h, block, six, glider, corner_blk, single, exp_glider;

  initial begin
    blink_v    = px(1,2) | px(2,2) | px(3,2);
    blink_h    = px(2,1) | px(2,2) | px(2,3);
    block      = px(1,1) | px(1,2) | px(2,1) | px(2,2);
    six        = px(1,1) | px(1,2) | px(1,3) | px(3,1) | px(3,2) | px(3,3);
    glider     = px(0,1) | px(1,2) | px(2,0) | px(2,1) | px(2,2);
    corner_blk = px(3,3) | px(3,4) | px(4,3) | px(4,4);
    single     = px(2,2);
`ifdef LIFE_BOARD_TORUS_EN
    exp_glider = glider;
`else
    exp_glider = corner_blk;
`endif

    rst = 1'b1; ena = 1'b0; load = 1'b0; init_state = blink_v;
    @(negedge clk);
    tick(2);
    chk("rst_cells", cells_a, blink_v);
    chk("rst_gen", gen_a, 0);
    chk("rst_still", still_a, 0);
    chk("rst_extinct", ext_a, 0);
    rst = 1'b0;

    tick(2);
    chk("hold_cells", cells_a, blink_v);
    chk("hold_gen", gen_a, 0);

    do_ena(1);
    chk("blink1_cells", cells_a, blink_h);
    chk("blink1_gen", gen_a, 1);
    do_ena(1);
    chk("blink2_cells", cells_a, blink_v);
    chk("blink2_gen", gen_a, 2);
    chk("blink2_still", still_a, 0);

    do_load(block);
    chk("load_gen", gen_a, 0);
    chk("load_cells", cells_a, block);
    do_ena(1);
    chk("block_cells", cells_a, block);
    chk("block_still", still_a, 1);
    chk("block_gen", gen_a, 1);
    do_load(blink_v);
    chk("load_clr_still", still_a, 0);

    do_load(six);
    do_ena(1);
    chk("b36_center", cells_b[2*C+2], 1);
    chk("b3_center", cells_a[2*C+2], 0);

    do_load(glider);
    do_ena(7);
    chk("gw3_gen7", gen_c, 7);
    do_ena(2);
    chk("gw3_sat", gen_c, 7);
    do_ena(11);
    chk("glider_cells", cells_a, exp_glider);
    chk("glider_gen", gen_a, 20);
`ifndef LIFE_BOARD_TORUS_EN
    chk("glider_still", still_a, 1);
`endif

    do_load(single);
    chk("single_extinct0", ext_a, 0);
    do_ena(1);
    chk("single_extinct1", ext_a, 1);
    chk("single_still0", still_a, 0);
    do_ena(1);
    chk("single_still1", still_a, 1);

    init_state = glider;
    rst = 1'b1; load = 1'b1; ena = 1'b1;
    tick(1);
    rst = 1'b0; load = 1'b0; ena = 1'b0;
    chk("rstovr_cells", cells_a, glider);
    chk("rstovr_gen", gen_a, 0);
    chk("rstovr_gen_c", gen_c, 0);
    chk("rstovr_still", still_a, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
